pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
// - Program-counter / fetch sequencer directly upstream of the instruction ROM/decoder; drives its 16-bit pc.
// - Sequences the program: waits for start, steps pc each cycle, redirects on jump / taken branch, stops on HALT.
// - Counts retired instructions for the testbench and a done flag for program completion.
// PARAMETERS
// - START_PC  16'd0   pc loaded on reset and on start
// - CNT_W     16      width of instr_count (saturating)
// PORTS
// - clk           in   1      single clock, rising edge
// - reset         in   1      synchronous, active-high
// - start         in   1      begin program execution (level, sampled per cycle)
// - stall         in   1      hold pc this cycle (data-memory wait)
// - halt_op       in   1      current instruction decodes as HALT (opcode 4'b1110)
// - jump          in   1      current instruction is unconditional jump
// - branch_taken  in   1      current branch condition evaluated true
// - target        in   16     absolute redirect address (decoder jmpLoc)
// - pc            out  16     address presented to instruction ROM
// - running       out  1      1 while in RUN
// - done          out  1      1 while in HALTED
// - instr_count   out  CNT_W  instructions retired since last start
// - branch_count  out  16     taken redirects since last start (see CONFIGURATION)
// BEHAVIOUR
// - Reset (synchronous, active-high): state=IDLE, pc=START_PC, running=0, done=0, instr_count=0, branch_count=0. Reset overrides all inputs incl. mid-RUN.
// - States: IDLE, RUN, HALTED; all outputs registered, update on rising clk.
// - IDLE: pc held at START_PC; start=1 -> RUN next cycle, counters cleared, pc stays START_PC (first fetch at START_PC).
// - RUN, per cycle, priority high->low:
//   1 stall=1: pc, counters, state unchanged; halt_op/jump/branch_taken ignored this cycle.
//   2 halt_op=1: -> HALTED; pc holds (points at HALT instr); instr_count +1 (HALT retires).
//   3 jump=1 or branch_taken=1: pc<=target; instr_count +1; branch_count +1. Both set simultaneously = single redirect, counted once.
//   4 else: pc<=pc+1, modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
// - start while RUN: ignored.
// - HALTED: pc, counters frozen; done=1. start=1 -> RUN, pc<=START_PC, counters cleared, done<=0.
// - running = (state==RUN); done = (state==HALTED); mutually exclusive, both 0 in IDLE.
// - instr_count saturates at all-ones (no wrap); branch_count saturates at 16'hFFFF.
// - Inputs halt_op/jump/branch_taken/target treated as combinational functions of the current pc (same cycle); no latency beyond the pc register: redirect visible on pc one cycle after sampling.
// - halt_op/jump/branch_taken in IDLE or HALTED: ignored.
// CONFIGURATION
// - Macro BRANCH_COUNT_EN.
// - Defined: branch_count register implemented as above.
// - Undefined: no branch counter logic; branch_count tied to 16'd0; all other behaviour identical.
// TESTING
// - Reset, then start=1 one cycle, no redirects -> pc 0,1,2,3 on successive cycles; running=1, done=0.
// - RUN at pc=8, branch_taken=1, target=16'd10 -> next pc=10, instr_count +1, branch_count=1 (0 if macro off).
// - stall=1 for 3 cycles at pc=5 with jump=1, target=0 -> pc stays 5, counts frozen; stall drops, jump still 1 -> pc=0.
// - halt_op=1 at pc=36 -> HALTED next cycle, pc=36, done=1, instr_count=37 from START_PC=0; later start=1 -> pc=0, counts 0, done=0.
// - Force pc=16'hFFFF via jump target, no redirect -> next pc=16'h0000, still RUN.
// - reset=1 mid-RUN at pc=20 with jump=1 -> next cycle IDLE, pc=START_PC, all counts 0, running=0, done=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus between the program-counter sequencer and the instruction
// ROM / decoder. The sequencer presents pc; the decoder answers in the same
// cycle with the control decode of the instruction at that pc.
interface pc_fetch_ctrl_if;
  logic [15:0] pc;
  logic        halt_op;
  logic        jump;
  logic        branch_taken;
  logic [15:0] target;

  modport master (
    output pc,
    input  halt_op,
    input  jump,
    input  branch_taken,
    input  target
  );

  modport slave (
    input  pc,
    output halt_op,
    output jump,
    output branch_taken,
    output target
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer. Waits in IDLE for start, steps pc each
// cycle in RUN, redirects on jump or taken branch, parks in HALTED on a HALT
// instruction. Counts retired instructions (saturating) and, when the
// BRANCH_COUNT_EN macro is defined, taken redirects (saturating). Without
// BRANCH_COUNT_EN the branch counter is absent and branch_count reads 0.
module pc_fetch_ctrl #(
  parameter logic [15:0] START_PC = 16'd0,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  pc_fetch_ctrl_if.master   bus,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count,
  output logic [15:0]       branch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t             state_r, state_n;
  logic [15:0]        pc_r, pc_n;
  logic               running_r, running_n;
  logic               done_r, done_n;
  logic [CNT_W-1:0]   ic_r, ic_n;
`ifdef BRANCH_COUNT_EN
  logic [15:0]        bc_r, bc_n;
`endif

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc_instr(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef BRANCH_COUNT_EN
  // 16-bit saturating increment for the redirect counter.
  function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Next-state and next-output decode; stall beats halt beats redirect beats step.
  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    ic_n    = ic_r;
`ifdef BRANCH_COUNT_EN
    bc_n    = bc_r;
`endif
    case (state_r)
      IDLE: begin
        pc_n = START_PC;
        if (start) begin
          state_n = RUN;
          ic_n    = {CNT_W{1'b0}};
`ifdef BRANCH_COUNT_EN
          bc_n    = 16'd0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (stall) begin
          state_n = RUN;
        end else if (bus.halt_op) begin
          // pc stays on the HALT instruction, which itself retires.
          state_n = HALTED;
          ic_n    = sat_inc_instr(ic_r);
        end else if (bus.jump || bus.branch_taken) begin
          // Jump and taken branch together are one redirect.
          pc_n = bus.target;
          ic_n = sat_inc_instr(ic_r);
`ifdef BRANCH_COUNT_EN
          bc_n = sat_inc_16(bc_r);
`endif
        end else begin
          pc_n = pc_r + 16'd1;
          ic_n = sat_inc_instr(ic_r);
        end
      end
      HALTED: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START_PC;
          ic_n    = {CNT_W{1'b0}};
`ifdef BRANCH_COUNT_EN
          bc_n    = 16'd0;
`endif
        end else begin
          state_n = HALTED;
        end
      end
      default: begin
        state_n = IDLE;
        pc_n    = START_PC;
      end
    endcase
    running_n = (state_n == RUN);
    done_n    = (state_n == HALTED);
  end

  // State, pc, flags and counters; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      pc_r      <= START_PC;
      running_r <= 1'b0;
      done_r    <= 1'b0;
      ic_r      <= {CNT_W{1'b0}};
`ifdef BRANCH_COUNT_EN
      bc_r      <= 16'd0;
`endif
    end else begin
      state_r   <= state_n;
      pc_r      <= pc_n;
      running_r <= running_n;
      done_r    <= done_n;
      ic_r      <= ic_n;
`ifdef BRANCH_COUNT_EN
      bc_r      <= bc_n;
`endif
    end
  end

  assign bus.pc      = pc_r;
  assign running     = running_r;
  assign done        = done_r;
  assign instr_count = ic_r;
`ifdef BRANCH_COUNT_EN
  assign branch_count = bc_r;
`else
  assign branch_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a table of per-cycle vectors plus a
// hand-written long run to a HALT instruction.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic        running, done;
  logic [15:0] instr_count, branch_count;
  int          total = 0;
  int          bad   = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.START_PC(16'd0), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .bus          (bus),
    .running      (running),
    .done         (done),
    .instr_count  (instr_count),
    .branch_count (branch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, stl, hlt, jmp, br;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic        e_run, e_done;
    logic [15:0] e_ic, e_bc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, st, stl, hlt, jmp, br,
                              input logic [15:0] tgt, e_pc,
                              input logic e_run, e_done,
                              input logic [15:0] e_ic, e_bc);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt; v.jmp = jmp; v.br = br;
    v.tgt = tgt; v.e_pc = e_pc; v.e_run = e_run; v.e_done = e_done;
    v.e_ic = e_ic; v.e_bc = e_bc;
    return v;
  endfunction

  function automatic logic [15:0] exp_bc(input logic [15:0] v);
`ifdef BRANCH_COUNT_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, stl, hlt, jmp, br, input logic [15:0] tgt);
    @(negedge clk);
    reset = rst; start = st; stall = stl;
    bus.halt_op = hlt; bus.jump = jmp; bus.branch_taken = br; bus.target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [15:0] e_pc, input logic e_run,
                           input logic e_done, input logic [15:0] e_ic, input logic [15:0] e_bc);
    chk("pc", idx, bus.pc, e_pc);
    chk("running", idx, {15'd0, running}, {15'd0, e_run});
    chk("done", idx, {15'd0, done}, {15'd0, e_done});
    chk("instr_count", idx, instr_count, e_ic);
    chk("branch_count", idx, branch_count, exp_bc(e_bc));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    bus.halt_op = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0; bus.target = 16'd0;

    //                 rst   st    stl   hlt   jmp   br    tgt        pc        run   done  ic      bc
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd0,     1'b0, 1'b0, 16'd0,  16'd0)); // reset
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5,     16'd0,     1'b0, 1'b0, 16'd0,  16'd0)); // idle ignores redirect
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd0,     1'b1, 1'b0, 16'd0,  16'd0)); // start
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd1,     1'b1, 1'b0, 16'd1,  16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd2,     1'b1, 1'b0, 16'd2,  16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd3,     1'b1, 1'b0, 16'd3,  16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd4,     1'b1, 1'b0, 16'd4,  16'd0)); // start in RUN ignored
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd5,     1'b1, 1'b0, 16'd5,  16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,     16'd5,     1'b1, 1'b0, 16'd5,  16'd0)); // stall x3
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,     16'd5,     1'b1, 1'b0, 16'd5,  16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,     16'd5,     1'b1, 1'b0, 16'd5,  16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,     16'd0,     1'b1, 1'b0, 16'd6,  16'd1)); // jump after stall
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8,     16'd8,     1'b1, 1'b0, 16'd7,  16'd2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd10,    16'd10,    1'b1, 1'b0, 16'd8,  16'd3)); // taken branch
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     16'd10,    1'b1, 1'b0, 16'd8,  16'd3)); // stall masks halt
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 16'd9,  16'd4)); // both: once
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'h0000,  1'b1, 1'b0, 16'd10, 16'd4)); // pc wraps
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd36,    16'd36,    1'b1, 1'b0, 16'd11, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3,     16'd36,    1'b0, 1'b1, 16'd12, 16'd5)); // halt beats jump
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7,     16'd36,    1'b0, 1'b1, 16'd12, 16'd5)); // halted frozen
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd0,     1'b1, 1'b0, 16'd0,  16'd0)); // restart
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20,    16'd20,    1'b1, 1'b0, 16'd1,  16'd1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd9,     16'd0,     1'b0, 1'b0, 16'd0,  16'd0)); // reset mid-RUN
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     16'd0,     1'b0, 1'b0, 16'd0,  16'd0)); // reset beats start

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].hlt, vecs[i].jmp, vecs[i].br, vecs[i].tgt);
      check_all(i, vecs[i].e_pc, vecs[i].e_run, vecs[i].e_done, vecs[i].e_ic, vecs[i].e_bc);
    end

    // Long run from START_PC to a HALT at pc=36: 36 steps then HALT retires.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check_all(100, 16'd0, 1'b1, 1'b0, 16'd0, 16'd0);
    for (int i = 1; i <= 36; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk("run_pc", 100 + i, bus.pc, 16'(i));
    end
    chk("run_ic", 137, instr_count, 16'd36);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    check_all(138, 16'd36, 1'b0, 1'b1, 16'd37, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check_all(139, 16'd36, 1'b0, 1'b1, 16'd37, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check_all(140, 16'd0, 1'b1, 1'b0, 16'd0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check_all(141, 16'd1, 1'b1, 1'b0, 16'd1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
